rr_arbiter4: RTL and testbench

RR_ARBITER4 -- requirements
Module: rr_arbiter4

---
 rtl/arb_pkg.sv | 10 +
 rtl/rr_pick4.sv | 33 +++
 rtl/rr_arbiter4.sv | 93 +++++++++
 tb/tb_rr_arbiter4.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the 4-way arbiter: FSM encoding and requester sizing.
package arb_pkg;
  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;
endpackage

// File: rtl/rr_pick4.sv
// Combinational winner select: round-robin from start, or highest index when rr_en=0.
// Zero latency; no flow control.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] start,
  input  logic             rr_en,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] w_pos;

  always_comb begin
    idx   = '0;
    w_pos = '0;
    if (rr_en) begin
      // Walk farthest-to-nearest so the nearest hit at/after start wins.
      for (int k = N_REQ - 1; k >= 0; k--) begin
        w_pos = start + IDX_W'(k);
        if (req[w_pos]) idx = w_pos;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req[i]) idx = IDX_W'(i);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/rr_arbiter4.sv
// 4-requester grant FSM with hold limit; grant registered one cycle after request sample.
// Grantee holds until done, request drop or MAX_HOLD; one idle cycle between grants.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int RR_EN    = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_id,
  output logic             busy,
  output logic             timeout
);

  localparam int             HW       = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]  HOLD_LIM = HW'(MAX_HOLD);

  state_t           r_state;
  logic [N_REQ-1:0] r_gnt;
  logic [IDX_W-1:0] r_gnt_id;
  logic [IDX_W-1:0] r_last;
  logic [HW-1:0]    r_hold;
  logic             r_timeout;

  logic [IDX_W-1:0] w_start;
  logic [IDX_W-1:0] w_idx;
  logic             w_any;
  logic             w_own;
  logic             w_hit_lim;
  logic             w_release;
  logic             w_forced;

  assign w_start   = r_last + IDX_W'(1);
  assign w_own     = req[r_gnt_id];
  assign w_hit_lim = (MAX_HOLD != 0) && (r_hold == HOLD_LIM);
  assign w_release = done || !w_own || w_hit_lim;
  // A coincident done makes the release a normal one.
  assign w_forced  = w_hit_lim && !done && w_own;

  rr_pick4 u_pick (
    .req   (req),
    .start (w_start),
    .rr_en (RR_EN != 0),
    .idx   (w_idx),
    .any   (w_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_gnt_id  <= '0;
      r_last    <= IDX_W'(N_REQ - 1);
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          r_hold <= '0;
          if (w_any) begin
            r_state  <= GRANT;
            r_gnt    <= N_REQ'(1) << w_idx;
            r_gnt_id <= w_idx;
            r_last   <= w_idx;
            r_hold   <= HW'(1);
          end
        end
        GRANT: begin
          if (w_release) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_hold    <= '0;
            r_timeout <= w_forced;
          end else begin
            r_hold <= r_hold + HW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign gnt_id  = r_gnt_id;
  assign busy    = (r_state == GRANT);
  assign timeout = r_timeout;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench: one round-robin and one fixed-priority arbiter, both MAX_HOLD=8.
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_rr = '0, req_fp = '0;
  logic       done_rr = 1'b0, done_fp = 1'b0;
  logic [3:0] gnt_rr, gnt_fp;
  logic [1:0] id_rr, id_fp;
  logic       busy_rr, busy_fp, to_rr, to_fp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rr_arbiter4 #(.RR_EN(1), .MAX_HOLD(8)) dut_rr (
    .clk(clk), .rst(rst), .req(req_rr), .done(done_rr),
    .gnt(gnt_rr), .gnt_id(id_rr), .busy(busy_rr), .timeout(to_rr)
  );

  rr_arbiter4 #(.RR_EN(0), .MAX_HOLD(8)) dut_fp (
    .clk(clk), .rst(rst), .req(req_fp), .done(done_fp),
    .gnt(gnt_fp), .gnt_id(id_fp), .busy(busy_fp), .timeout(to_fp)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({gnt_rr, id_rr, busy_rr, to_rr} !== 8'b0000_00_0_0) begin
      n_fail++;
      $display("FAIL reset_rr: got gnt=%b id=%0d busy=%b to=%b, want 0000/0/0/0", gnt_rr, id_rr, busy_rr, to_rr);
    end
    n_checks++;
    if ({gnt_fp, id_fp, busy_fp, to_fp} !== 8'b0000_00_0_0) begin
      n_fail++;
      $display("FAIL reset_fp: got gnt=%b id=%0d busy=%b to=%b, want 0000/0/0/0", gnt_fp, id_fp, busy_fp, to_fp);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_idle();
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if ({gnt_rr, busy_rr, to_rr} !== 6'b0000_0_0) begin
        n_fail++;
        $display("FAIL idle[%0d]: got gnt=%b busy=%b to=%b, want 0000/0/0", k, gnt_rr, busy_rr, to_rr);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [14] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0100,
                               4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001, 4'b0001};
    req_rr = 4'b1111;
    for (int k = 1; k <= 14; k++) begin
      step();
      n_checks++;
      if (gnt_rr !== exp_g[k-1] || busy_rr !== (exp_g[k-1] != 4'b0000) || to_rr !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_seq[%0d]: got gnt=%b busy=%b to=%b, want gnt=%b", k, gnt_rr, busy_rr, to_rr, exp_g[k-1]);
      end
      done_rr = (k % 3 == 2);
    end
    step();
    req_rr  = 4'b0000;
    done_rr = 1'b0;
    step();
    step();
  endtask

  task automatic test_fixed_priority();
    req_fp = 4'b0110;
    step();
    n_checks++;
    if (gnt_fp !== 4'b0100 || id_fp !== 2'd2) begin
      n_fail++;
      $display("FAIL fp_first: got gnt=%b id=%0d, want 0100/2", gnt_fp, id_fp);
    end
    // Other request lines change while bit 2 stays asserted.
    req_fp = 4'b0111;
    step();
    n_checks++;
    if (gnt_fp !== 4'b0100 || id_fp !== 2'd2) begin
      n_fail++;
      $display("FAIL fp_stable1: got gnt=%b id=%0d, want 0100/2", gnt_fp, id_fp);
    end
    req_fp = 4'b0101;
    step();
    n_checks++;
    if (gnt_fp !== 4'b0100 || id_fp !== 2'd2) begin
      n_fail++;
      $display("FAIL fp_stable2: got gnt=%b id=%0d, want 0100/2", gnt_fp, id_fp);
    end
    done_fp = 1'b1;
    step();
    n_checks++;
    if (gnt_fp !== 4'b0000 || id_fp !== 2'd2 || to_fp !== 1'b0 || busy_fp !== 1'b0) begin
      n_fail++;
      $display("FAIL fp_done_release: got gnt=%b id=%0d to=%b busy=%b, want 0000/2/0/0", gnt_fp, id_fp, to_fp, busy_fp);
    end
    req_fp = 4'b0011;
    step();
    n_checks++;
    if (gnt_fp !== 4'b0010 || id_fp !== 2'd1) begin
      n_fail++;
      $display("FAIL fp_done_in_idle: got gnt=%b id=%0d, want 0010/1", gnt_fp, id_fp);
    end
    done_fp = 1'b0;
    step();
    n_checks++;
    if (gnt_fp !== 4'b0010) begin
      n_fail++;
      $display("FAIL fp_hold: got gnt=%b, want 0010", gnt_fp);
    end
    req_fp = 4'b0000;
    step();
    n_checks++;
    if (gnt_fp !== 4'b0000 || id_fp !== 2'd1) begin
      n_fail++;
      $display("FAIL fp_drop: got gnt=%b id=%0d, want 0000/1", gnt_fp, id_fp);
    end
  endtask

  task automatic test_timeout();
    req_rr = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_checks++;
      if (gnt_rr !== 4'b0001 || busy_rr !== 1'b1 || to_rr !== 1'b0) begin
        n_fail++;
        $display("FAIL to_hold[%0d]: got gnt=%b busy=%b to=%b, want 0001/1/0", k, gnt_rr, busy_rr, to_rr);
      end
    end
    step();
    n_checks++;
    if (gnt_rr !== 4'b0000 || to_rr !== 1'b1) begin
      n_fail++;
      $display("FAIL to_pulse: got gnt=%b to=%b, want 0000/1", gnt_rr, to_rr);
    end
    step();
    n_checks++;
    if (gnt_rr !== 4'b0001 || to_rr !== 1'b0) begin
      n_fail++;
      $display("FAIL to_regrant: got gnt=%b to=%b, want 0001/0", gnt_rr, to_rr);
    end
    // Ride to the limit again, this time with done arriving on the last cycle.
    for (int k = 2; k <= 8; k++) step();
    done_rr = 1'b1;
    step();
    n_checks++;
    if (gnt_rr !== 4'b0000 || to_rr !== 1'b0) begin
      n_fail++;
      $display("FAIL to_done_coincide: got gnt=%b to=%b, want 0000/0", gnt_rr, to_rr);
    end
    done_rr = 1'b0;
    req_rr  = 4'b0000;
    step();
  endtask

  task automatic test_req_drop();
    req_rr = 4'b0100;
    step();
    n_checks++;
    if (gnt_rr !== 4'b0100 || id_rr !== 2'd2) begin
      n_fail++;
      $display("FAIL drop_grant: got gnt=%b id=%0d, want 0100/2", gnt_rr, id_rr);
    end
    req_rr = 4'b0000;
    step();
    n_checks++;
    if (gnt_rr !== 4'b0000 || to_rr !== 1'b0 || id_rr !== 2'd2) begin
      n_fail++;
      $display("FAIL drop_release: got gnt=%b to=%b id=%0d, want 0000/0/2", gnt_rr, to_rr, id_rr);
    end
    step();
  endtask

  task automatic test_reset_midgrant();
    req_rr = 4'b0100;
    step();
    n_checks++;
    if (gnt_rr !== 4'b0100) begin
      n_fail++;
      $display("FAIL rst_pre: got gnt=%b, want 0100", gnt_rr);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (gnt_rr !== 4'b0000 || busy_rr !== 1'b0 || id_rr !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_async: got gnt=%b busy=%b id=%0d, want 0000/0/0", gnt_rr, busy_rr, id_rr);
    end
    req_rr = 4'b1111;
    step();
    rst = 1'b0;
    step();
    n_checks++;
    if (gnt_rr !== 4'b0001 || id_rr !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_first_grant: got gnt=%b id=%0d, want 0001/0", gnt_rr, id_rr);
    end
    req_rr = 4'b0000;
    step();
  endtask

  initial begin
    test_reset();
    test_idle();
    test_round_robin();
    test_fixed_priority();
    test_timeout();
    test_req_drop();
    test_reset_midgrant();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
